stream_max_finder: RTL and testbench
====================================

# stream_max_finder

Streaming maximum-finder for unsigned samples. It accepts one sample per cycle over a valid/ready handshake and groups every FRAME_LEN accepted samples into a frame. For each frame it returns the largest value and the position of that value within the frame, holding the result until the consumer takes it. It is the sequential, framed max-side counterpart to the registered min-compare tree used elsewhere in the datapath, and sits between a sample source and a downstream peak consumer.

## Interface
- WIDTH, 8: sample width in bits, ≥1.
- FRAME_LEN, 4: samples per frame, ≥2.
- IDX_W, $clog2(FRAME_LEN): index width (derived, not overridden).
- clk  in  1  sole clock; all logic on posedge.
- rst_n  in  1  reset; **asynchronous, active-low**.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block can accept a sample; high exactly when the state is ACCUM.
- in_data  in  WIDTH  unsigned sample.
- flush  in  1  synchronous discard of the partial frame.
- out_valid  out  1  result valid, held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_max  out  WIDTH  frame maximum.
- out_idx  out  IDX_W  0-based position of the maximum within the frame.

## Operation
- **States:**
  - ACCUM (the reset state): collects samples.
  - DONE: holds the result.
- **Accept:** a sample is taken when in_valid && in_ready. Counter cnt (IDX_W bits, reset 0) holds the position of the next sample.
- **Sample at cnt==0:** loads run_max=in_data and run_idx=0 unconditionally.
- **Sample at cnt>0:**
  - If in_data > run_max (strict, unsigned), load run_max=in_data and run_idx=cnt.
  - Otherwise hold.
  - Ties keep the earliest index.
- **Sample at cnt==FRAME_LEN-1:**
  - Apply the compare above, including this last sample.
  - Register the result into out_max/out_idx and set out_valid=1.
  - Reset cnt to 0 and go to DONE.
- **DONE:**
  - in_ready=0.
  - out_valid, out_max and out_idx are held stable.
  - On out_valid && out_ready: clear out_valid and return to ACCUM.
  - out_max/out_idx keep their last values after acceptance.
- **flush in ACCUM:**
  - cnt←0; run_max/run_idx are don't-care.
  - A sample presented in the same cycle is not accepted, even though in_ready=1. flush has priority.
- **flush in DONE:** ignored; the pending result is not lost.
- **Non-accept cycles:** in_valid=0 in ACCUM leaves cnt and the running values unchanged. Gaps within a frame are allowed.
- **Wrap-around:** cnt never exceeds FRAME_LEN-1. This also holds when FRAME_LEN is not a power of two.
- **Reset values:** state=ACCUM, cnt=0, run_max=0, run_idx=0, out_valid=0, out_max=0, out_idx=0.
  - in_ready=1 once the state is ACCUM, including while reset is asserted.
- **Reset mid-frame or mid-DONE:** the partial frame or pending result is discarded. The next accepted sample is index 0.

## Timing
- in_ready is combinational from state only. There is no path from in_valid, out_ready or flush to in_ready.
- **Latency:** last sample accepted at edge T gives out_valid=1 with the result visible after edge T.
- **Out handshake:** out_ready sampled high at edge T+k clears out_valid after that edge. in_ready is 1 in the following cycle.
- **Throughput:** at most FRAME_LEN samples per FRAME_LEN+1 cycles when out_ready is held high.
- out_max, out_idx and out_valid are registered outputs. There are no combinational input-to-output paths on the result side.

## Test plan
All scenarios use WIDTH=8 and FRAME_LEN=4.
- **Basic frame:** in_valid continuous, samples 3,9,2,7, out_ready=1.
  - out_valid=1 one cycle after the 4th accept, with out_max=9, out_idx=1.
  - in_ready=0 for exactly one cycle.
- **Ties and extremes:** samples 5,200,200,255 gives out_max=255, out_idx=3. Samples 0,0,0,0 gives out_max=0, out_idx=0. Samples 8,8,1,8 gives out_idx=0.
- **Backpressure:** frame 1,2,3,4 with out_ready=0 for 5 cycles.
  - out_valid and out_max=4, out_idx=3 stay stable; in_ready=0 throughout.
  - After out_ready=1 for one cycle, out_valid=0 and in_ready=1.
- **Gaps and flush:**
  - Accept 50,60, then 2 idle cycles, then flush=1 together with in_valid=1 and data 99.
  - 99 is not accepted. The next frame 10,40,30,20 gives out_max=40, out_idx=1.
  - flush pulsed during DONE leaves the result intact.
- **Reset mid-operation:**
  - Assert rst_n=0 asynchronously after 2 samples. All outputs go to their reset values immediately, without waiting for a clock edge.
  - After release, frame 4,3,2,1 gives out_max=4, out_idx=0.
  - Assert reset while in DONE: out_valid drops at once.
- **Back-to-back frames:** 8 samples 1..8 continuous with out_ready=1.
  - Results (4,3) then (8,3), each one cycle after its last accept.
  - No sample is lost or duplicated across the DONE cycle.

Source files
------------

// File: rtl/stream_max_finder_if.sv
// Sample-in / result-out bundle for stream_max_finder; slave is the finder, master is the source/consumer side.
interface stream_max_finder_if #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4
);
   localparam int IDX_W = $clog2(FRAME_LEN);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_max;
   logic [IDX_W-1:0] out_idx;

   modport slave (
      input  in_valid, in_data, flush, out_ready,
      output in_ready, out_valid, out_max, out_idx
   );

   modport master (
      output in_valid, in_data, flush, out_ready,
      input  in_ready, out_valid, out_max, out_idx
   );
endinterface

// File: rtl/stream_max_finder.sv
// Framed running max (earliest index wins ties); result registered one edge after the last accept.
// Input stalls (in_ready=0) only while a result is held for an out_valid/out_ready handshake.
module stream_max_finder #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4
) (
   input logic                i_clk,
   input logic                i_rst_n,
   stream_max_finder_if.slave bus
);
   localparam int IDX_W = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_run_max;
   logic [IDX_W-1:0] r_run_idx;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_max;
   logic [IDX_W-1:0] r_out_idx;

   logic             w_accept;
   logic             w_flush;
   logic             w_last;
   logic             w_take_new;
   logic [WIDTH-1:0] w_cand_max;
   logic [IDX_W-1:0] w_cand_idx;

   // The first sample of a frame always seeds the running max; later ones need a strict win.
   assign w_last     = (r_cnt == LAST_IDX);
   assign w_take_new = (r_cnt == '0) || (bus.in_data > r_run_max);
   assign w_cand_max = w_take_new ? bus.in_data : r_run_max;
   assign w_cand_idx = w_take_new ? r_cnt : r_run_idx;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_flush     = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            w_flush  = bus.flush;
            w_accept = bus.in_valid && !bus.flush;
            if (w_accept && w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = ST_ACCUM;
            end
         end
         default: w_state_nxt = ST_ACCUM;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt       <= '0;
         r_run_max   <= '0;
         r_run_idx   <= '0;
         r_out_valid <= 1'b0;
         r_out_max   <= '0;
         r_out_idx   <= '0;
      end else if (w_flush) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_run_max <= w_cand_max;
         r_run_idx <= w_cand_idx;
         if (w_last) begin
            r_cnt       <= '0;
            r_out_max   <= w_cand_max;
            r_out_idx   <= w_cand_idx;
            r_out_valid <= 1'b1;
         end else begin
            r_cnt <= r_cnt + IDX_W'(1);
         end
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = (r_state == ST_ACCUM);
   assign bus.out_valid = r_out_valid;
   assign bus.out_max   = r_out_max;
   assign bus.out_idx   = r_out_idx;
endmodule

// File: tb/tb_stream_max_finder.sv
// Bench for stream_max_finder: frame model feeds an expected-result queue, a separate monitor pops on each new result.
module tb_stream_max_finder;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   q_max[$];
   int   q_idx[$];
   int   frames_made = 0;
   int   frames_seen = 0;

   always #5 clk = ~clk;

   stream_max_finder_if #(.WIDTH(8), .FRAME_LEN(4)) sif ();

   stream_max_finder #(.WIDTH(8), .FRAME_LEN(4)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (sif)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: collect accepted samples; a full frame yields (largest, first position of it).
   int  part[$];
   bit  lat_pend = 1'b0;
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         part.delete();
         q_max.delete();
         q_idx.delete();
         lat_pend = 1'b0;
      end else begin
         if (lat_pend) begin
            check("latency_out_valid", int'(sif.out_valid), 1);
            lat_pend = 1'b0;
         end
         if (sif.in_ready && sif.flush) begin
            part.delete();
         end else if (sif.in_ready && sif.in_valid) begin
            part.push_back(int'(sif.in_data));
            if (part.size() == 4) begin
               int m;
               int mi;
               m  = -1;
               mi = 0;
               foreach (part[k]) begin
                  if (part[k] > m) begin
                     m  = part[k];
                     mi = k;
                  end
               end
               q_max.push_back(m);
               q_idx.push_back(mi);
               frames_made++;
               part.delete();
               lat_pend = 1'b1;
            end
         end
      end
   end

   bit seen = 1'b0;
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen = 1'b0;
      end else begin
         if (sif.out_valid && !seen) begin
            frames_seen++;
            if (q_max.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               check("sb_out_max", int'(sif.out_max), q_max.pop_front());
               check("sb_out_idx", int'(sif.out_idx), q_idx.pop_front());
            end
            seen = 1'b1;
         end
         if (sif.out_valid && sif.out_ready) seen = 1'b0;
      end
   end

   task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
      sif.in_valid  = v;
      sif.in_data   = d;
      sif.flush     = f;
      sif.out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic r);
      int   n;
      logic acc;
      n             = 0;
      sif.in_valid  = 1'b1;
      sif.in_data   = d;
      sif.flush     = 1'b0;
      sif.out_ready = r;
      do begin
         acc = sif.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 50);
      if (!acc) check("send_timeout", 0, 1);
      sif.in_valid = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b0;
      sif.in_valid  = 1'b0;
      sif.in_data   = '0;
      sif.flush     = 1'b0;
      sif.out_ready = 1'b0;
      #2;
      check("rst_in_ready", int'(sif.in_ready), 1);
      check("rst_out_valid", int'(sif.out_valid), 0);
      check("rst_out_max", int'(sif.out_max), 0);
      check("rst_out_idx", int'(sif.out_idx), 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic frame
      send(8'd3, 1'b1); send(8'd9, 1'b1); send(8'd2, 1'b1); send(8'd7, 1'b1);
      check("basic_in_ready_low", int'(sif.in_ready), 0);
      check("basic_max", int'(sif.out_max), 9);
      check("basic_idx", int'(sif.out_idx), 1);
      step(1'b0, 8'd0, 1'b0, 1'b1);
      check("basic_in_ready_back", int'(sif.in_ready), 1);
      check("basic_valid_clear", int'(sif.out_valid), 0);

      // Ties and extremes
      send(8'd5, 1'b1); send(8'd200, 1'b1); send(8'd200, 1'b1); send(8'd255, 1'b1);
      check("ext_max", int'(sif.out_max), 255);
      check("ext_idx", int'(sif.out_idx), 3);
      repeat (4) send(8'd0, 1'b1);
      check("zero_max", int'(sif.out_max), 0);
      send(8'd8, 1'b1); send(8'd8, 1'b1); send(8'd1, 1'b1); send(8'd8, 1'b1);
      check("tie_idx", int'(sif.out_idx), 0);
      step(1'b0, 8'd0, 1'b0, 1'b1);

      // Backpressure
      send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'd77, 1'b0, 1'b0);
         check("bp_valid", int'(sif.out_valid), 1);
         check("bp_max", int'(sif.out_max), 4);
         check("bp_idx", int'(sif.out_idx), 3);
         check("bp_in_ready", int'(sif.in_ready), 0);
      end
      step(1'b0, 8'd0, 1'b0, 1'b1);
      check("bp_release_valid", int'(sif.out_valid), 0);
      check("bp_release_ready", int'(sif.in_ready), 1);

      // Gaps and flush
      send(8'd50, 1'b1); send(8'd60, 1'b1);
      step(1'b0, 8'd0, 1'b0, 1'b1);
      step(1'b0, 8'd0, 1'b0, 1'b1);
      step(1'b1, 8'd99, 1'b1, 1'b1);
      send(8'd10, 1'b0); send(8'd40, 1'b0); send(8'd30, 1'b0); send(8'd20, 1'b0);
      check("flush_max", int'(sif.out_max), 40);
      check("flush_idx", int'(sif.out_idx), 1);
      step(1'b0, 8'd0, 1'b1, 1'b0);
      check("done_flush_valid", int'(sif.out_valid), 1);
      check("done_flush_max", int'(sif.out_max), 40);
      check("done_flush_idx", int'(sif.out_idx), 1);
      step(1'b0, 8'd0, 1'b0, 1'b1);

      // Asynchronous reset mid-frame, then mid-DONE
      send(8'd1, 1'b1); send(8'd2, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_in_ready", int'(sif.in_ready), 1);
      check("arst_out_valid", int'(sif.out_valid), 0);
      check("arst_out_max", int'(sif.out_max), 0);
      check("arst_out_idx", int'(sif.out_idx), 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(8'd4, 1'b0); send(8'd3, 1'b0); send(8'd2, 1'b0); send(8'd1, 1'b0);
      check("post_rst_max", int'(sif.out_max), 4);
      check("post_rst_idx", int'(sif.out_idx), 0);
      step(1'b0, 8'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_done_valid", int'(sif.out_valid), 0);
      check("arst_done_ready", int'(sif.in_ready), 1);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back frames 1..8
      for (int i = 1; i <= 8; i++) send(8'(i), 1'b1);
      check("b2b_max", int'(sif.out_max), 8);
      check("b2b_idx", int'(sif.out_idx), 3);
      step(1'b0, 8'd0, 1'b0, 1'b1);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         step(1'(($urandom % 4) != 0), 8'($urandom), 1'(($urandom % 20) == 0),
              1'(($urandom % 3) != 0));
      end
      repeat (4) step(1'b0, 8'd0, 1'b0, 1'b1);
      check("drain_queue_empty", q_max.size(), 0);
      check("result_count", frames_seen, frames_made);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
